mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port, byte-wide program/data memory between three requesters: the instruction fetch stage, the execution unit's load/store path, and a memory loader port used for boot-time image loading.
- Fetch reads are two-byte bursts. Byte at addr is {opcode, field}; byte at addr+1 is the operand. They are returned as one 16-bit word.
- Sits inside cpu_top, between the fetch/exec units and the memory instance.

Parameters:
- ADDR_BITS, 8, memory byte-address width (256-byte space).
- DATA_BITS, 8, memory data width.
- STARVE_LIMIT, 4, maximum consecutive data-port grants while fetch_req is pending.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ld_req  input  1  loader write request.
- ld_addr  input  ADDR_BITS  loader write address.
- ld_wdata  input  DATA_BITS  loader write data.
- ld_gnt  output  1  loader request accepted this cycle.
- data_req  input  1  load/store request.
- data_we  input  1  1 = store, 0 = load.
- data_addr  input  ADDR_BITS  load/store address.
- data_wdata  input  DATA_BITS  store data.
- data_gnt  output  1  data request accepted this cycle.
- data_done  output  1  one-cycle completion pulse.
- data_rdata  output  DATA_BITS  load result; valid while data_done=1.
- fetch_req  input  1  instruction fetch request.
- fetch_addr  input  ADDR_BITS  address of the instruction's first byte.
- fetch_gnt  output  1  fetch request accepted this cycle.
- fetch_valid  output  1  one-cycle pulse; instruction word ready.
- fetch_instr  output  2*DATA_BITS  {byte[addr], byte[addr+1]}; valid while fetch_valid=1.
- mem_en  output  1  memory access this cycle.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_BITS  memory address.
- mem_wdata  output  DATA_BITS  memory write data.
- mem_rdata  input  DATA_BITS  memory read data; valid one cycle after a read cycle (en=1, we=0).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the starvation counter clears.
  - All gnt, done and valid outputs and mem_en/mem_we are 0; mem_addr, mem_wdata, data_rdata and fetch_instr are 0.
  - A transaction in flight is aborted with no done/valid pulse. A write either already happened in its grant cycle or never happens.
- Handshake:
  - A request is accepted on the clock edge where req=1 and gnt=1.
  - gnt is combinational, asserted only in IDLE, and to at most one requester.
  - Address and data are sampled in the grant cycle. The requester may change them or drop req afterwards.
  - req held high after a grant is treated as a new request in the next IDLE cycle.
- States: IDLE, LD_WR, DATA_RD, DATA_WR, FETCH_HI, FETCH_LO.
- IDLE:
  - Selects a winner; priority is ld > data > fetch, except that the starvation override below forces fetch.
  - The grant cycle drives the memory directly: mem_en=1, mem_addr = winner's address, mem_we=1 for loader or store, mem_wdata = write data.
- Next state from IDLE:
  - loader -> LD_WR
  - load -> DATA_RD
  - store -> DATA_WR
  - fetch -> FETCH_HI, with the fetch address latched.
  - no request -> IDLE, mem_en=0.
- LD_WR: no memory access; -> IDLE. The loader has no done signal; ld_gnt is its completion.
- DATA_WR: data_done=1; -> IDLE.
- DATA_RD: data_done=1, data_rdata=mem_rdata; -> IDLE.
- FETCH_HI: capture mem_rdata as the high byte; drive a read at (latched addr+1) mod 2^ADDR_BITS; -> FETCH_LO.
- FETCH_LO:
  - fetch_valid=1, fetch_instr={hi, mem_rdata}; -> IDLE.
  - fetch_instr holds its value until the next fetch completes.
- Latency from grant cycle N:
  - data_done at N+1.
  - fetch_valid at N+2.
  - Fastest back-to-back rate: one data op per 2 cycles, one fetch per 3 cycles.
- Bursts: a fetch burst is never interrupted. A loader or data request arriving during FETCH_HI/FETCH_LO waits for IDLE.
- Wrap-around: fetch_addr = 2^ADDR_BITS-1 reads its second byte from address 0.
- Starvation counter:
  - Increments on each data grant made while fetch_req=1.
  - Clears on a fetch grant or whenever fetch_req=0 in IDLE.
  - When the counter equals STARVE_LIMIT, fetch wins IDLE even if data_req=1.
  - Loader priority is absolute and loader grants do not touch the counter.
- Simultaneous events: all three requesting in IDLE -> ld_gnt only; the others stay pending with gnt=0.

Test Plan:
- Reset release, memory preloaded [0]=0x00, [1]=0x00, [2]=0x20, [3]=0x10; fetch_req with addr=2 -> fetch_gnt in cycle N, mem_addr=2 then 3, fetch_valid at N+2 with fetch_instr=0x2010.
- Store data_addr=0x10, wdata=0x07, then load 0x10 -> mem_we=1 in the store grant cycle; data_done at N+1 for each; load data_rdata=0x07.
- ld_req, data_req and fetch_req asserted together and held -> grant order ld, data, fetch; exactly one gnt per IDLE cycle; no gnt in non-IDLE states.
- fetch_req held while data_req issues 6 back-to-back loads -> fetch granted after exactly 4 data grants; remaining loads complete after fetch_valid.
- fetch_addr=0xFF with [0xFF]=0xA5, [0x00]=0x3C -> fetch_instr=0xA53C.
- reset driven low in FETCH_HI and asynchronously mid-cycle -> all outputs 0 immediately; no fetch_valid; after release, state is IDLE and a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for the shared byte-wide memory used by the loader, the load/store
// path and instruction fetch. Fetches are two-byte bursts returned as one word.
module mem_arbiter #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ld_req,
    input  logic [ADDR_BITS-1:0]   ld_addr,
    input  logic [DATA_BITS-1:0]   ld_wdata,
    output logic                   ld_gnt,

    input  logic                   data_req,
    input  logic                   data_we,
    input  logic [ADDR_BITS-1:0]   data_addr,
    input  logic [DATA_BITS-1:0]   data_wdata,
    output logic                   data_gnt,
    output logic                   data_done,
    output logic [DATA_BITS-1:0]   data_rdata,

    input  logic                   fetch_req,
    input  logic [ADDR_BITS-1:0]   fetch_addr,
    output logic                   fetch_gnt,
    output logic                   fetch_valid,
    output logic [2*DATA_BITS-1:0] fetch_instr,

    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS-1:0]   mem_wdata,
    input  logic [DATA_BITS-1:0]   mem_rdata,

    output logic [2:0]             dbg_state
);

    // Handshake: a requester is accepted on the rising edge where req=1 and
    // gnt=1. gnt is combinational, only asserted in IDLE, and one-hot. Address
    // and data are sampled in that grant cycle; req may drop afterwards.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_WR    = 3'd1,
        DATA_RD  = 3'd2,
        DATA_WR  = 3'd3,
        FETCH_HI = 3'd4,
        FETCH_LO = 3'd5
    } state_t;

    localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);

    state_t                 state;
    logic [ADDR_BITS-1:0]   fetch_addr_q;
    logic [DATA_BITS-1:0]   hi_q;
    logic [2*DATA_BITS-1:0] instr_q;
    logic [CNT_BITS-1:0]    starve_cnt;

    logic in_idle;
    logic starve;

    assign in_idle   = reset && (state == IDLE);
    assign starve    = fetch_req && (starve_cnt >= CNT_BITS'(STARVE_LIMIT));

    assign ld_gnt    = in_idle && ld_req;
    assign data_gnt  = in_idle && !ld_req && data_req && !starve;
    assign fetch_gnt = in_idle && !ld_req && fetch_req && (!data_req || starve);

    assign data_done   = (state == DATA_RD) || (state == DATA_WR);
    assign data_rdata  = (state == DATA_RD) ? mem_rdata : '0;
    assign fetch_valid = (state == FETCH_LO);
    // The low byte arrives in the FETCH_LO cycle itself, so the word is
    // forwarded combinationally then and held in instr_q afterwards.
    assign fetch_instr = fetch_valid ? {hi_q, mem_rdata} : instr_q;
    assign dbg_state   = state;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (data_gnt) begin
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_addr  = data_addr;
            mem_wdata = data_we ? data_wdata : '0;
        end else if (fetch_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = fetch_addr;
        end else if (state == FETCH_HI) begin
            mem_en    = 1'b1;
            mem_addr  = fetch_addr_q + ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fetch_addr_q <= '0;
            hi_q         <= '0;
            instr_q      <= '0;
            starve_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_gnt) begin
                        state <= LD_WR;
                    end else if (data_gnt) begin
                        state <= data_we ? DATA_WR : DATA_RD;
                    end else if (fetch_gnt) begin
                        state        <= FETCH_HI;
                        fetch_addr_q <= fetch_addr;
                    end
                    // Loader grants leave the count alone; data cannot win at
                    // the limit while fetch waits, so the count never overflows.
                    if (fetch_gnt || !fetch_req) begin
                        starve_cnt <= '0;
                    end else if (data_gnt) begin
                        starve_cnt <= starve_cnt + CNT_BITS'(1);
                    end
                end
                LD_WR, DATA_RD, DATA_WR: state <= IDLE;
                FETCH_HI: begin
                    hi_q  <= mem_rdata;
                    state <= FETCH_LO;
                end
                FETCH_LO: begin
                    instr_q <= {hi_q, mem_rdata};
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, driver tasks and a
// scoreboard fed at grant time and drained at data_done / fetch_valid.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ld_req;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_gnt;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [7:0]  data_wdata;
  logic        data_gnt;
  logic        data_done;
  logic [7:0]  data_rdata;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  dbg_state;

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
    .data_rdata(data_rdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"}, 32'({ld_gnt, data_gnt, fetch_gnt}), 32'd0);
    check_eq({tag, "_pulse"}, 32'({data_done, fetch_valid}), 32'd0);
    check_eq({tag, "_mem_ctl"}, 32'({mem_en, mem_we}), 32'd0);
    check_eq({tag, "_mem_bus"}, 32'({mem_addr, mem_wdata}), 32'd0);
    check_eq({tag, "_rdata"}, 32'(data_rdata), 32'd0);
    check_eq({tag, "_instr"}, 32'(fetch_instr), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0]  ref_mem [256];
  logic [8:0]  exp_d_q[$];   // {is_load, expected rdata}
  logic [15:0] exp_f_q[$];
  logic        dg_d1 = 1'b0;
  logic        fg_d1 = 1'b0;
  logic        fg_d2 = 1'b0;
  logic [7:0]  fa_d1 = 8'd0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_d_q.delete();
      exp_f_q.delete();
      dg_d1 <= 1'b0;
      fg_d1 <= 1'b0;
      fg_d2 <= 1'b0;
    end else begin
      if (ld_gnt || data_gnt || fetch_gnt) begin
        check_eq("gnt_onehot", 32'(ld_gnt) + 32'(data_gnt) + 32'(fetch_gnt), 32'd1);
        check_eq("gnt_in_idle", 32'(dbg_state), 32'd0);
        check_eq("grant_mem_en", 32'(mem_en), 32'd1);
      end
      if (ld_gnt) begin
        check_eq("ld_mem", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, ld_addr, ld_wdata}));
        ref_mem[ld_addr] <= ld_wdata;
      end
      if (data_gnt) begin
        check_eq("data_mem", 32'({mem_we, mem_addr}), 32'({data_we, data_addr}));
        if (data_we) begin
          check_eq("store_wdata", 32'(mem_wdata), 32'(data_wdata));
          ref_mem[data_addr] <= data_wdata;
          exp_d_q.push_back({1'b0, data_wdata});
        end else begin
          exp_d_q.push_back({1'b1, ref_mem[data_addr]});
        end
      end
      if (fetch_gnt) begin
        check_eq("fetch_mem", 32'({mem_we, mem_addr}), 32'({1'b0, fetch_addr}));
        exp_f_q.push_back({ref_mem[fetch_addr], ref_mem[8'(fetch_addr + 8'd1)]});
      end
      if (fg_d1)
        check_eq("fetch_hi_mem", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 8'(fa_d1 + 8'd1)}));
      if (data_done || dg_d1)
        check_eq("data_latency", 32'(data_done), 32'(dg_d1));
      if (data_done && exp_d_q.size() > 0) begin
        if (exp_d_q[0][8]) check_eq("data_rdata", 32'(data_rdata), 32'(exp_d_q[0][7:0]));
        exp_d_q.delete(0);
      end
      if (fetch_valid || fg_d2)
        check_eq("fetch_latency", 32'(fetch_valid), 32'(fg_d2));
      if (fetch_valid && exp_f_q.size() > 0) begin
        check_eq("fetch_instr", 32'(fetch_instr), 32'(exp_f_q[0]));
        exp_f_q.delete(0);
      end
      dg_d1 <= data_gnt;
      fg_d1 <= fetch_gnt;
      fg_d2 <= fg_d1;
      fa_d1 <= fetch_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if ((which == 0 && ld_gnt) || (which == 1 && data_gnt) || (which == 2 && fetch_gnt))
        ok = 1'b1;
    end
    check_eq("gnt_timeout", 32'(ok), 32'd1);
  endtask

  task automatic ld_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = a; ld_wdata = d;
    wait_gnt(0);
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  task automatic data_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    data_req = 1'b1; data_we = we; data_addr = a; data_wdata = d;
    wait_gnt(1);
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic fetch_op(input logic [7:0] a);
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = a;
    wait_gnt(2);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  int order [3];
  int nk, nd, fetch_at, fv_cyc, last_done;
  bit gl, gd, gf, fetched;

  initial begin
    reset = 1'b0;
    ld_req = 1'b0; ld_addr = 8'd0; ld_wdata = 8'd0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 8'd0; data_wdata = 8'd0;
    fetch_req = 1'b0; fetch_addr = 8'd0;
    idle(3); #1;
    check_quiet("reset");
    @(negedge clk); reset = 1'b1;

    // boot image and first fetch
    ld_write(8'h00, 8'h00);
    ld_write(8'h01, 8'h00);
    ld_write(8'h02, 8'h20);
    ld_write(8'h03, 8'h10);
    for (int i = 0; i < 6; i++) ld_write(8'(8'h20 + i), 8'($urandom_range(0, 255)));
    fetch_op(8'h02);
    idle(3);
    check_eq("instr_hold", 32'(fetch_instr), 32'h2010);

    // store then load
    data_op(1'b1, 8'h10, 8'h07);
    data_op(1'b0, 8'h10, 8'h00);
    idle(2);

    // all three requesting together
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = 8'h30; ld_wdata = 8'h5A;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h21;
    fetch_req = 1'b1; fetch_addr = 8'h02;
    nk = 0;
    for (int i = 0; i < 20 && nk < 3; i++) begin
      @(negedge clk);
      gl = ld_gnt; gd = data_gnt; gf = fetch_gnt;
      if (gl || gd || gf) begin
        order[nk] = gl ? 1 : (gd ? 2 : 3);
        nk++;
      end
      @(posedge clk); #1;
      if (gl) ld_req = 1'b0;
      if (gd) data_req = 1'b0;
      if (gf) fetch_req = 1'b0;
    end
    check_eq("prio_count", 32'(nk), 32'd3);
    check_eq("prio_first", 32'(order[0]), 32'd1);
    check_eq("prio_second", 32'(order[1]), 32'd2);
    check_eq("prio_third", 32'(order[2]), 32'd3);
    idle(4);

    // starvation: fetch held against six back-to-back loads
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h20;
    fetch_req = 1'b1; fetch_addr = 8'h02;
    nd = 0; fetched = 1'b0; fetch_at = -1; fv_cyc = 0; last_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gd = data_gnt; gf = fetch_gnt;
      if (data_done) last_done = cyc;
      if (fetch_valid) fv_cyc = cyc;
      if (gf) begin fetch_at = nd; fetched = 1'b1; end
      if (gd) nd++;
      @(posedge clk); #1;
      if (gd) begin
        if (nd == 6) data_req = 1'b0;
        else data_addr = 8'(8'h20 + nd);
      end
      if (gf) fetch_req = 1'b0;
    end
    check_eq("starve_fetched", 32'(fetched), 32'd1);
    check_eq("starve_grants", 32'(fetch_at), 32'd4);
    check_eq("starve_loads", 32'(nd), 32'd6);
    check_eq("starve_tail", 32'(last_done > fv_cyc), 32'd1);

    // address wrap on the second fetch byte
    ld_write(8'hFF, 8'hA5);
    ld_write(8'h00, 8'h3C);
    fetch_op(8'hFF);
    idle(3);
    check_eq("wrap_hold", 32'(fetch_instr), 32'hA53C);

    // randomized mix in a preloaded window
    for (int i = 0; i < 16; i++) ld_write(8'(8'h40 + i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: ld_write(8'(8'h40 + $urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        1: data_op(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 15)),
                   8'($urandom_range(0, 255)));
        default: fetch_op(8'(8'h40 + $urandom_range(0, 14)));
      endcase
    end
    idle(4);

    // asynchronous reset in the middle of a fetch burst
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 8'h02;
    wait_gnt(2);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_quiet("rst_async");
    fetch_req = 1'b0;
    idle(2); #3;
    reset = 1'b1;
    idle(4);
    check_eq("rst_instr", 32'(fetch_instr), 32'd0);
    fetch_op(8'h02);
    idle(3);
    check_eq("rst_refetch", 32'(fetch_instr), 32'h2010);

    idle(4);
    check_eq("sb_data_drain", 32'(exp_d_q.size()), 32'd0);
    check_eq("sb_fetch_drain", 32'(exp_f_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
